sample_1_sweep_ctrl: RTL and testbench
======================================

Name: sample_1_sweep_ctrl

Overview:
Sequencer that drives the 3-input combinational datapath sample_1_data through every input vector and captures its output into a truth-table register.
- Hardware self-characterisation of the datapath with a start/done handshake; replaces manual bench sweeps.
- Sits between a control master (start/abort) and one sample_1_data instance: vec drives {a,b,c}, o_in is fed by o.

Parameters:
N_IN, 3, number of datapath inputs; vectors swept 0..2**N_IN-1.
HOLD, 2, cycles each vector is held before sampling; legal range 1..255; 0 is illegal and caught by an elaboration check.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  pulse/level; accepted in IDLE or DONE
abort  input  1  cancels an active sweep
o_in  input  1  datapath output o
vec  output  N_IN  drives {a,b,c}; a=MSB, c=LSB
busy  output  1  high while sweeping
done  output  1  one-cycle pulse, sweep complete
truth  output  2**N_IN  bit k = o_in captured for vec==k
ones_cnt  output  N_IN+1  number of 1s captured in the sweep

Behaviour:
- Reset (async, rst=1): state IDLE; vec=0, busy=0, done=0, truth=0, ones_cnt=0, hold counter=0. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE/DONE to RUN: on an edge with start=1 and abort=0.
  - At that edge: vec<=0, hold counter<=0, truth<=0, ones_cnt<=0, busy<=1.
- RUN, per vector:
  - vec is held for exactly HOLD cycles; hold counter counts 0..HOLD-1.
  - At the edge where hold counter==HOLD-1: truth[vec]<=o_in, ones_cnt<=ones_cnt+o_in, hold counter<=0.
  - On that same edge, if vec<2**N_IN-1 then vec<=vec+1; else go to DONE.
- Latency: start accepted at edge T0; vector k is sampled at edge T0+HOLD*(k+1); done is high for the single cycle after edge T0+HOLD*2**N_IN. N_IN=3, HOLD=2: done in the cycle after edge T0+16.
- DONE: done=1, busy=0, vec=0. truth and ones_cnt are final and stable until the next accepted start.
  - Next edge goes to IDLE, unless start=1, which restarts RUN back-to-back.
- Arithmetic:
  - vec increments with no wrap inside RUN; the terminal vector ends the sweep.
  - ones_cnt is N_IN+1 bits wide and cannot overflow (max 2**N_IN).
- start while in RUN: ignored; no restart.
- abort in RUN: next edge goes to IDLE with busy=0, vec=0, no done. truth/ones_cnt keep their partial values.
- abort in IDLE/DONE: no effect except that it suppresses a simultaneous start (abort wins).
- o_in is sampled only at sample edges; values between sample edges are don't-care.

Optional Feature:
SAMPLE_1_SWEEP_CHECK_EN
- Defined:
  - Adds input expect [2**N_IN-1:0], output mismatch (1 bit) and output fail_idx [N_IN-1:0].
  - At each sample edge, if o_in != expect[vec], mismatch is set sticky and fail_idx records the first failing vec.
  - Both are cleared on an accepted start and on reset (reset value 0).
  - Final values are valid when done=1.
- Not defined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sample_1_pkg:
  - state enum sweep_state_t {IDLE, RUN, DONE};
  - default N_IN=3;
  - HOLD_W=8, the width of the hold counter;
  - localparam-style helper NUM_VEC = 2**N_IN.
- One sub-module: sample_1_hold_cnt.
  - HOLD_W-bit counter with clear and enable.
  - Output last = (cnt==HOLD-1).
- Top FSM, vec counter and truth capture stay in sample_1_sweep_ctrl.

Test Plan:
Bench model for o_in is o = (a&b)|c, with sample_1_data connected.
- Full sweep, N_IN=3, HOLD=2: start pulse at edge T0 -> vec steps 0..7, each held 2 cycles; done one cycle after T0+16; truth=8'hEA, ones_cnt=5, busy low with done.
- HOLD=1: start -> done in the cycle after T0+8; truth=8'hEA; vec changes every cycle.
- Abort: abort asserted while vec=3 -> next cycle busy=0, vec=0, no done pulse; truth bits 0..2 = 3'b010, ones_cnt=1.
- Back-to-back and ignored starts:
  - start held high through DONE -> new sweep starts immediately, truth cleared, second done after another 16 cycles.
  - start during RUN -> no effect.
- Async reset at vec=5 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
  - Subsequent start -> a normal full sweep.
- SAMPLE_1_SWEEP_CHECK_EN: expect=8'hEA -> mismatch=0.
  - expect=8'hE8 -> mismatch=1, fail_idx=1.
  - Cleared by the next start.

Source files
------------

// File: rtl/sample_1_pkg.sv
// Purpose : shared types and constants for the sample_1 datapath sweep sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package sample_1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int N_IN_DEFAULT = 3;
    localparam int HOLD_W       = 8;
    localparam int NUM_VEC      = 2 ** N_IN_DEFAULT;

    // Number of input vectors for an n-input datapath.
    function automatic int num_vec(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sample_1_hold_cnt.sv
// Purpose : per-vector dwell counter; counts 0..HOLD-1 and flags the sample cycle.
// Latency : last is combinational from the registered count.
// Backpressure: none; clr dominates en.
// Ports   : clk, rst (async active-high), clr, en, last (= cnt==HOLD-1).
module sample_1_hold_cnt
    import sample_1_pkg::*;
#(
    parameter int HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    assign last = (cnt_q == HOLD_W'(HOLD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_1_sweep_ctrl.sv
// Purpose : sweeps a combinational datapath through all 2**N_IN vectors and
//           captures its output into a truth table (start/done handshake).
// Latency : vector k sampled HOLD*(k+1) edges after start; done pulses the cycle
//           after edge T0+HOLD*2**N_IN.
// Backpressure: start ignored while busy; abort wins over start.
// Ports   : clk, rst, start, abort, o_in -> vec, busy, done, truth, ones_cnt.
//           Optional build macro SAMPLE_1_SWEEP_CHECK_EN adds expect_val input and
//           mismatch / fail_idx outputs (golden-table comparison).
module sample_1_sweep_ctrl
    import sample_1_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT,
    parameter int HOLD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       o_in,
`ifdef SAMPLE_1_SWEEP_CHECK_EN
    input  logic [num_vec(N_IN)-1:0]   expect_val,
    output logic                       mismatch,
    output logic [N_IN-1:0]            fail_idx,
`endif
    output logic [N_IN-1:0]            vec,
    output logic                       busy,
    output logic                       done,
    output logic [num_vec(N_IN)-1:0]   truth,
    output logic [N_IN:0]              ones_cnt
);

    localparam int NV = num_vec(N_IN);
    localparam int CW = N_IN + 1;

    generate
        if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
            $error("sample_1_sweep_ctrl: HOLD must be in 1..255");
        end
    endgenerate

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NV-1:0]   truth_q, truth_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic            last;
    logic            start_ok;
    logic            sample;

    // Counter runs only while sweeping; leaving RUN (or aborting) parks it at 0
    // so the first vector of the next sweep gets its full dwell.
    sample_1_hold_cnt #(.HOLD(HOLD)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state_q != RUN) || abort),
        .en   (state_q == RUN),
        .last (last)
    );

    assign start_ok = start && !abort;
    assign sample   = (state_q == RUN) && !abort && last;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        truth_d = truth_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                vec_d  = '0;
                if (start_ok) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    truth_d = '0;
                    ones_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    // Partial truth/ones_cnt are deliberately retained.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    vec_d   = '0;
                end else if (sample) begin
                    truth_d[vec_q] = o_in;
                    ones_d         = ones_q + CW'(o_in);
                    if (vec_q == N_IN'(NV - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            truth_q <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            truth_q <= truth_d;
            ones_q  <= ones_d;
        end
    end

    assign vec      = vec_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign truth    = truth_q;
    assign ones_cnt = ones_q;

`ifdef SAMPLE_1_SWEEP_CHECK_EN
    logic            mism_q, mism_d;
    logic [N_IN-1:0] fidx_q, fidx_d;

    // Sticky flag; fail_idx freezes on the first failing vector only.
    always_comb begin
        mism_d = mism_q;
        fidx_d = fidx_q;
        if (start_ok && (state_q != RUN)) begin
            mism_d = 1'b0;
            fidx_d = '0;
        end else if (sample && (o_in != expect_val[vec_q]) && !mism_q) begin
            mism_d = 1'b1;
            fidx_d = vec_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mism_q <= 1'b0;
            fidx_q <= '0;
        end else begin
            mism_q <= mism_d;
            fidx_q <= fidx_d;
        end
    end

    assign mismatch = mism_q;
    assign fail_idx = fidx_q;
`endif

endmodule

// File: tb/tb_sample_1_sweep_ctrl.sv
// Purpose : self-checking bench for sample_1_sweep_ctrl (HOLD=2 and HOLD=1 instances),
//           datapath modelled as o = (a&b)|c.
// Latency : expected done cycle is carried in each scoreboard record.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_sample_1_sweep_ctrl;

    typedef struct {
        logic [7:0] truth;
        logic [3:0] ones;
        int         cyc;
        logic       mism;
        logic [2:0] fidx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    // DUT0: HOLD=2
    logic       start0 = 1'b0, abort0 = 1'b0, o0;
    logic [2:0] vec0;
    logic       busy0, done0;
    logic [7:0] truth0;
    logic [3:0] ones0;
    // DUT1: HOLD=1
    logic       start1 = 1'b0, abort1 = 1'b0, o1;
    logic [2:0] vec1;
    logic       busy1, done1;
    logic [7:0] truth1;
    logic [3:0] ones1;
`ifdef SAMPLE_1_SWEEP_CHECK_EN
    logic [7:0] expect_val0 = 8'hEA;
    logic [7:0] expect_val1 = 8'hEA;
    logic       mism0, mism1;
    logic [2:0] fidx0, fidx1;
`endif

    assign o0 = (vec0[2] & vec0[1]) | vec0[0];
    assign o1 = (vec1[2] & vec1[1]) | vec1[0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_1_sweep_ctrl #(.N_IN(3), .HOLD(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .o_in(o0),
`ifdef SAMPLE_1_SWEEP_CHECK_EN
        .expect_val(expect_val0), .mismatch(mism0), .fail_idx(fidx0),
`endif
        .vec(vec0), .busy(busy0), .done(done0), .truth(truth0), .ones_cnt(ones0)
    );

    sample_1_sweep_ctrl #(.N_IN(3), .HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .o_in(o1),
`ifdef SAMPLE_1_SWEEP_CHECK_EN
        .expect_val(expect_val1), .mismatch(mism1), .fail_idx(fidx1),
`endif
        .vec(vec1), .busy(busy1), .done(done1), .truth(truth1), .ones_cnt(ones1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop the expected record whenever a DUT pulses done.
    always @(negedge clk) begin : mon0
        if (!rst && done0 === 1'b1) begin
            if (q0.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done0: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("truth0", 32'(truth0), 32'(e0.truth));
                chk("ones0", 32'(ones0), 32'(e0.ones));
                chk("done0_cycle", cyc, e0.cyc);
                chk("busy0_at_done", 32'(busy0), 32'd0);
                chk("vec0_at_done", 32'(vec0), 32'd0);
`ifdef SAMPLE_1_SWEEP_CHECK_EN
                chk("mismatch0", 32'(mism0), 32'(e0.mism));
                if (e0.mism) chk("fail_idx0", 32'(fidx0), 32'(e0.fidx));
`endif
            end
        end
    end

    always @(negedge clk) begin : mon1
        if (!rst && done1 === 1'b1) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done1: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("truth1", 32'(truth1), 32'(e1.truth));
                chk("ones1", 32'(ones1), 32'(e1.ones));
                chk("done1_cycle", cyc, e1.cyc);
                chk("busy1_at_done", 32'(busy1), 32'd0);
`ifdef SAMPLE_1_SWEEP_CHECK_EN
                chk("mismatch1", 32'(mism1), 32'(e1.mism));
`endif
            end
        end
    end

    // Start DUT0 with a one-edge pulse; t0 = index of the accepting edge.
    task automatic launch0(input bit push, input logic [7:0] tt, input logic [3:0] on,
                           input logic mm, input logic [2:0] fi, output int t0);
        exp_t r;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        t0 = cyc;
        if (push) begin
            r.truth = tt; r.ones = on; r.cyc = t0 + 16; r.mism = mm; r.fidx = fi;
            q0.push_back(r);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic wait_vec0(input logic [2:0] v, input string nm);
        int n = 0;
        while (vec0 !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(vec0), 32'(v));
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   t0;
        exp_t r;

        // Reset state
        #12;
        chk("rst_vec0", 32'(vec0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_truth0", 32'(truth0), 0);
        chk("rst_ones0", 32'(ones0), 0);
        chk("rst_busy1", 32'(busy1), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full sweep HOLD=2, with an ignored start pulse mid-run
        launch0(1'b1, 8'hEA, 4'd5, 1'b0, 3'd0, t0);
        chk("run_busy0", 32'(busy0), 1);
        chk("run_vec0", 32'(vec0), 0);
        @(negedge clk);
        chk("hold_vec0_second_cycle", 32'(vec0), 0);
        @(negedge clk);
        chk("vec0_step", 32'(vec0), 1);
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain("sweep_hold2");

        // HOLD=1 sweep: vec steps every cycle, done after T0+8
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        t0 = cyc;
        r.truth = 8'hEA; r.ones = 4'd5; r.cyc = t0 + 8; r.mism = 1'b0; r.fidx = 3'd0;
        q1.push_back(r);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("vec1_step%0d", k), 32'(vec1), 32'(k));
            @(negedge clk);
        end
        drain("sweep_hold1");

        // Abort at vec=3: partial capture kept, no done
        launch0(1'b0, 8'h00, 4'd0, 1'b0, 3'd0, t0);
        wait_vec0(3'd3, "abort_reach_vec3");
        abort0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_busy0", 32'(busy0), 0);
        chk("abort_vec0", 32'(vec0), 0);
        chk("abort_done0", 32'(done0), 0);
        chk("abort_truth0_lo", 32'(truth0[2:0]), 32'h2);
        chk("abort_ones0", 32'(ones0), 1);
        repeat (20) @(negedge clk);
        chk("abort_still_idle", 32'(busy0), 0);

        // Abort suppresses a simultaneous start in IDLE
        start0 = 1'b1;
        abort0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        chk("abort_wins_busy0", 32'(busy0), 0);
        chk("abort_wins_truth0", 32'(truth0[2:0]), 32'h2);

        // Back-to-back: start held through DONE restarts immediately
        launch0(1'b1, 8'hEA, 4'd5, 1'b0, 3'd0, t0);
        start0 = 1'b1;
        r.truth = 8'hEA; r.ones = 4'd5; r.cyc = t0 + 33; r.mism = 1'b0; r.fidx = 3'd0;
        q0.push_back(r);
        repeat (17) @(negedge clk);
        start0 = 1'b0;
        chk("b2b_truth_cleared", 32'(truth0), 0);
        chk("b2b_ones_cleared", 32'(ones0), 0);
        chk("b2b_busy0", 32'(busy0), 1);
        drain("sweep_b2b");

        // Async reset mid-cycle at vec=5
        launch0(1'b0, 8'h00, 4'd0, 1'b0, 3'd0, t0);
        wait_vec0(3'd5, "rst_reach_vec5");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vec0", 32'(vec0), 0);
        chk("arst_busy0", 32'(busy0), 0);
        chk("arst_truth0", 32'(truth0), 0);
        chk("arst_ones0", 32'(ones0), 0);
        chk("arst_done0", 32'(done0), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch0(1'b1, 8'hEA, 4'd5, 1'b0, 3'd0, t0);
        drain("sweep_after_rst");

`ifdef SAMPLE_1_SWEEP_CHECK_EN
        expect_val0 = 8'hE8;
        launch0(1'b1, 8'hEA, 4'd5, 1'b1, 3'd1, t0);
        drain("sweep_check_bad");
        expect_val0 = 8'hEA;
        launch0(1'b1, 8'hEA, 4'd5, 1'b0, 3'd0, t0);
        chk("check_cleared_on_start", 32'(mism0), 0);
        drain("sweep_check_good");
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
